// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences each instruction and drives
// every datapath enable, mux select and the memory write strobe.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  ctrl_t  ctrl_q;

  function automatic state_t next_of(
    input state_t     s,
    input logic [5:0] o
  );
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE: begin
        case (o)
          OP_LW,
          OP_SW:   n = MEMADR;
          OP_RTYP: n = RTYPEEX;
          OP_BEQ:  n = BEQEX;
          OP_ADDI: n = ADDIEX;
          OP_J:    n = JEX;
          default: n = FETCH;
        endcase
      end
      MEMADR:  n = (o == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   n = MEMWB;
      RTYPEEX: n = RTYPEWB;
      ADDIEX:  n = ADDIWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] alu_of(
    input logic [5:0] f
  );
    logic [2:0] a;
    case (f)
      6'b100000: a = ALU_ADD;
      6'b100010: a = ALU_SUB;
      6'b100100: a = ALU_AND;
      6'b100101: a = ALU_OR;
      6'b101010: a = ALU_SLT;
      default:   a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic ctrl_t ctrl_of(
    input state_t     s,
    input logic [5:0] f
  );
    ctrl_t c;
    c = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca    = 1'b1;
        c.alucontrol = alu_of(f);
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca    = 1'b1;
        c.alucontrol = ALU_SUB;
        c.pcsrc      = 2'b01;
        c.branch     = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c.alucontrol = ALU_ADD;
    endcase
    return c;
  endfunction

  // Outputs are registered alongside the state, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH, 6'b000000);
    end else begin
      state_q <= next_of(state_q, op);
      ctrl_q  <= ctrl_of(next_of(state_q, op), funct);
    end
  end

  // Registers already hold FETCH values in reset; mask the enables.
  assign pcen     = ~reset
                  & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
  assign irwrite  = ~reset & ctrl_q.irwrite;
  assign regwrite = ~reset & ctrl_q.regwrite;
  assign memwrite = ~reset & ctrl_q.memwrite;

  assign alusrca    = ctrl_q.alusrca;
  assign iord       = ctrl_q.iord;
  assign memtoreg   = ctrl_q.memtoreg;
  assign regdst     = ctrl_q.regdst;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsrc      = ctrl_q.pcsrc;
  assign alucontrol = ctrl_q.alucontrol;
  assign state      = state_q;

endmodule
